wsg_voice_sched: RTL

WSG_VOICE_SCHED -- requirements
Module: wsg_voice_sched

---
 rtl/wsg_voice_sched.sv | 94 +++++++++
 1 files changed

// File: rtl/wsg_voice_sched.sv
// wsg_voice_sched: 3-voice wavetable sound scheduler, one PROM fetch per voice slot, mixed sample every 3 slots.
module wsg_voice_sched #(
  parameter int CLK_HZ  = 34800000,
  parameter int SLOT_HZ = 72000
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       reg_we,
  input  logic [4:0] reg_addr,
  input  logic [3:0] reg_wdata,
  output logic       rom_rd,
  output logic [8:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [9:0] sample_out,
  output logic       sample_valid,
  output logic       busy
);
  localparam int DIV = CLK_HZ / SLOT_HZ;
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_ACC} state_t;
  state_t state, state_nxt;

  logic [3:0]    regs [32];
  logic [19:0]   phase [3];
  logic [CW-1:0] cnt;
  logic          slot_start;
  logic [1:0]    v;
  logic [4:0]    b;
  logic [3:0]    vol, rom_q;
  logic [19:0]   freq;
  logic [9:0]    sum, p;

  // Base of the current voice's 5-register block.
  assign b = {1'b0, v, 2'b00} + {3'b000, v};
  assign p = 10'(vol) * (10'(rom_q) - 10'd7);

  always_ff @(posedge clk_pixel) assert (DIV >= 4) else $error("wsg_voice_sched: CLK_HZ/SLOT_HZ must be >= 4");

  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[reg_addr] <= reg_wdata;
    end

  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      cnt        <= '0;
      slot_start <= 1'b0;
      state      <= S_IDLE;
    end else begin
      cnt        <= cnt == CW'(DIV - 1) ? '0 : cnt + CW'(1);
      slot_start <= cnt == CW'(DIV - 1);
      state      <= state_nxt;
    end

  always_comb begin
    state_nxt = state == S_IDLE  ? (slot_start ? S_FETCH : S_IDLE) :
                state == S_FETCH ? S_WAIT :
                state == S_WAIT  ? S_ACC : S_IDLE;
    rom_rd    = state == S_FETCH;
    rom_addr  = rom_rd ? {regs[b + 5'h05], phase[v][17:13]} : '0;
    busy      = state != S_IDLE;
  end

  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) phase[i] <= '0;
      v            <= '0;
      vol          <= '0;
      freq         <= '0;
      rom_q        <= '0;
      sum          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (state == S_FETCH) begin
        vol  <= regs[b + 5'h15];
        freq <= {regs[b + 5'h14], regs[b + 5'h13], regs[b + 5'h12], regs[b + 5'h11], v == 2'd0 ? regs[5'h10] : 4'h0};
      end
      if (state == S_WAIT) rom_q <= rom_data;
      if (state == S_ACC) begin
        phase[v] <= phase[v] + freq;
        sum      <= v == 2'd0 ? p : sum + p;
        v        <= v == 2'd2 ? 2'd0 : v + 2'd1;
        if (v == 2'd2) begin
          sample_out   <= sum + p;
          sample_valid <= 1'b1;
        end
      end
    end
endmodule
